// File: rtl/breakout_pixel_gen_if.sv
// Pixel-stream and player-control bundle between the video sync stage and breakout_pixel_gen.
interface breakout_pixel_gen_if;
    logic        pTick;
    logic        videoON;
    logic [9:0]  pixelX;
    logic [9:0]  pixelY;
    logic        btnLeft;
    logic        btnRight;
    logic [11:0] rgb;
    logic [3:0]  missCount;

    modport master (output pTick, videoON, pixelX, pixelY, btnLeft, btnRight,
                    input  rgb, missCount);
    modport slave  (input  pTick, videoON, pixelX, pixelY, btnLeft, btnRight,
                    output rgb, missCount);
endinterface

// File: rtl/breakout_pixel_gen.sv
// Breakout game state (paddle, ball, misses) and registered per-pixel colour.
// Define BALL_ROUND_EN to draw the ball through an 8x8 round bitmap instead of a square.
module breakout_pixel_gen #(
    parameter int PADDLE_STEP = 4,
    parameter int BALL_SPEED  = 2
) (
    input logic clock,
    input logic reset,
    breakout_pixel_gen_if.slave bus
);
    localparam logic [9:0] STEP    = 10'(PADDLE_STEP);
    localparam logic [9:0] SPD     = 10'(BALL_SPEED);
    localparam logic [9:0] SPD_NEG = 10'(-BALL_SPEED);

    logic [9:0]  paddle_x, ball_x, ball_y, vx, vy;
    logic [9:0]  vx_n, vy_n, paddle_n;
    logic [11:0] rgb_q, colour;
    logic [3:0]  miss_q;
    logic        frame_tick, in_box, ball_bit, in_ball, in_paddle, in_wall;
    logic [10:0] bl, bt, br, bb, pl, pr, x, y;

    // Edges are carried in 11 bits so +7/+71 never wraps in comparisons.
    assign bl = {1'b0, ball_x};
    assign bt = {1'b0, ball_y};
    assign br = bl + 11'd7;
    assign bb = bt + 11'd7;
    assign pl = {1'b0, paddle_x};
    assign pr = pl + 11'd71;
    assign x  = {1'b0, bus.pixelX};
    assign y  = {1'b0, bus.pixelY};

    assign frame_tick = bus.pTick && (bus.pixelX == 10'd0) && (bus.pixelY == 10'd481);

    // Later rules win: the paddle bounce overrides the top-wall bounce on vy.
    always_comb begin
        vx_n = vx;
        vy_n = vy;
        if (bl <= 11'd8)   vx_n = SPD;
        if (br >= 11'd631) vx_n = SPD_NEG;
        if (bt <= 11'd8)   vy_n = SPD;
        if (bb >= 11'd450 && bb <= 11'd453 && br >= pl && bl <= pr) vy_n = SPD_NEG;
    end

    always_comb begin
        paddle_n = paddle_x;
        if (bus.btnLeft && !bus.btnRight)
            paddle_n = (paddle_x < 10'd8 + STEP) ? 10'd8 : paddle_x - STEP;
        else if (bus.btnRight && !bus.btnLeft)
            paddle_n = (paddle_x + STEP > 10'd560) ? 10'd560 : paddle_x + STEP;
    end

    assign in_box = (x >= bl) && (x <= br) && (y >= bt) && (y <= bb);

`ifdef BALL_ROUND_EN
    logic [9:0] dx, dy;
    logic [7:0] rom_row;
    assign dx = bus.pixelX - ball_x;
    assign dy = bus.pixelY - ball_y;
    always_comb begin
        case (dy[2:0])
            3'd0, 3'd7: rom_row = 8'h3C;
            3'd1, 3'd6: rom_row = 8'h7E;
            default:    rom_row = 8'hFF;
        endcase
    end
    // MSB is the leftmost column of the ball box.
    assign ball_bit = rom_row[3'd7 - dx[2:0]];
`else
    assign ball_bit = 1'b1;
`endif

    assign in_ball   = in_box && ball_bit;
    assign in_paddle = (y >= 11'd450) && (y <= 11'd453) && (x >= pl) && (x <= pr);
    assign in_wall   = (x <= 11'd7) || (x >= 11'd632 && x <= 11'd639) || (y <= 11'd7);

    always_comb begin
        colour = 12'h000;
        if (in_ball)        colour = 12'hF00;
        else if (in_paddle) colour = 12'h0F0;
        else if (in_wall)   colour = 12'h00F;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rgb_q    <= 12'h000;
            miss_q   <= 4'd0;
            paddle_x <= 10'd284;
            ball_x   <= 10'd316;
            ball_y   <= 10'd236;
            vx       <= SPD;
            vy       <= SPD;
        end else if (bus.pTick) begin
            rgb_q <= bus.videoON ? colour : 12'h000;
            if (frame_tick) begin
                paddle_x <= paddle_n;
                if (ball_y >= 10'd472) begin
                    ball_x <= 10'd316;
                    ball_y <= 10'd236;
                    vx     <= SPD;
                    vy     <= SPD;
                    if (miss_q != 4'd15) miss_q <= miss_q + 4'd1;
                end else begin
                    vx     <= vx_n;
                    vy     <= vy_n;
                    ball_x <= ball_x + vx_n;
                    ball_y <= ball_y + vy_n;
                end
            end
        end
    end

    assign bus.rgb       = rgb_q;
    assign bus.missCount = miss_q;
endmodule

// File: tb/tb_breakout_pixel_gen.sv
// Scoreboard bench: randomized frames and pixel probes against an integer game model.
module tb_breakout_pixel_gen;
    localparam int STEP = 4;
    localparam int SPD  = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    breakout_pixel_gen_if bus();
    breakout_pixel_gen #(.PADDLE_STEP(STEP), .BALL_SPEED(SPD)) dut (
        .clock(clock), .reset(reset), .bus(bus));

    typedef struct packed { logic [11:0] rgb; logic [3:0] miss; } exp_t;
    exp_t q[$];
    int n_cmp = 0, n_bad = 0;
    int px, bx, by, vx, vy, miss;
    logic [11:0] last_rgb = 12'h000;

`ifdef BALL_ROUND_EN
    int rom[8] = '{8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7E, 8'h3C};
`endif

    function automatic logic [11:0] colour(input int x, input int y);
        if (x >= bx && x <= bx + 7 && y >= by && y <= by + 7) begin
`ifdef BALL_ROUND_EN
            if (((rom[y - by] >> (7 - (x - bx))) & 1) == 1) return 12'hF00;
`else
            return 12'hF00;
`endif
        end
        if (y >= 450 && y <= 453 && x >= px && x <= px + 71) return 12'h0F0;
        if (x <= 7 || (x >= 632 && x <= 639) || y <= 7) return 12'h00F;
        return 12'h000;
    endfunction

    task automatic model_reset();
        px = 284; bx = 316; by = 236; vx = SPD; vy = SPD; miss = 0;
    endtask

    task automatic model_frame(input bit l, input bit r);
        if (by >= 472) begin
            bx = 316; by = 236; vx = SPD; vy = SPD;
            if (miss < 15) miss++;
        end else begin
            if (bx <= 8) vx = SPD;
            if (bx + 7 >= 631) vx = -SPD;
            if (by <= 8) vy = SPD;
            if (by + 7 >= 450 && by + 7 <= 453 && bx + 7 >= px && bx <= px + 71) vy = -SPD;
            bx = (bx + vx) & 1023;
            by = (by + vy) & 1023;
        end
        if (l && !r) px = (px - STEP < 8) ? 8 : px - STEP;
        else if (r && !l) px = (px + STEP > 560) ? 560 : px + STEP;
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive(input int x, input int y, input bit tick, input bit off);
        exp_t e;
        bit   vid;
        @(negedge clock);
        vid = (x < 640) && (y < 480) && !off;
        bus.pixelX  = 10'(x);
        bus.pixelY  = 10'(y);
        bus.pTick   = tick;
        bus.videoON = vid;
        if (tick) begin
            e.rgb = vid ? colour(x, y) : 12'h000;
            if (x == 0 && y == 481) model_frame(bus.btnLeft, bus.btnRight);
            e.miss = 4'(miss);
            q.push_back(e);
        end
    endtask

    task automatic do_reset(input bit mid);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check(mid ? "mid_reset_rgb" : "reset_rgb", int'(bus.rgb), 0);
        check(mid ? "mid_reset_miss" : "reset_miss", int'(bus.missCount), 0);
        q.delete();
        last_rgb = 12'h000;
        model_reset();
        bus.pTick = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Monitor: every pTick edge must produce the next queued colour; otherwise rgb holds.
    logic t, rs;
    exp_t got;
    initial begin
        forever begin
            @(posedge clock);
            t  = bus.pTick && reset;
            rs = reset;
            #1;
            if (t) begin
                if (q.size() == 0) begin
                    check("queue_underflow", 1, 0);
                end else begin
                    got = q.pop_front();
                    check("rgb", int'(bus.rgb), int'(got.rgb));
                    check("missCount", int'(bus.missCount), int'(got.miss));
                    last_rgb = got.rgb;
                end
            end else if (rs && reset) begin
                check("rgb_hold", int'(bus.rgb), int'(last_rgb));
            end
        end
    end

    initial begin
        int  rx, ry, bc, pc;
        bit  l, r;
        int  pts[11][2];
        reset = 1'b1;
        bus.pTick = 1'b0; bus.videoON = 1'b0; bus.pixelX = '0; bus.pixelY = '0;
        bus.btnLeft = 1'b0; bus.btnRight = 1'b0;
        #2 reset = 1'b0;
        #2;
        check("reset_rgb", int'(bus.rgb), 0);
        check("reset_miss", int'(bus.missCount), 0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;

        drive(320, 240, 1, 0);
        drive(0, 100, 1, 0);
        drive(300, 451, 1, 0);
        drive(320, 300, 1, 0);
        drive(320, 240, 1, 1);
        drive(5, 5, 0, 0);

        for (int f = 0; f < 3600; f++) begin
            if (f == 600) do_reset(1);
            bc = bx + 4;
            pc = px + 36;
            if (f < 100)       begin l = 0; r = 1; end
            else if (f < 150)  begin l = 1; r = 1; end
            else if (f < 600)  begin l = bc < pc; r = bc > pc; end
            else if (f < 3200) begin l = bc >= pc; r = !l; end
            else               begin l = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1)); end
            bus.btnLeft  = l;
            bus.btnRight = r;
            drive(0, 481, 1, 0);

            pts = '{'{bx, by}, '{bx + 7, by + 7}, '{bx - 1, by + 3}, '{bx + 8, by + 3},
                    '{bx + 3, by - 1}, '{bx + 3, by}, '{px, 451}, '{px - 1, 450},
                    '{px + 71, 453}, '{px + 72, 452},
                    '{int'($urandom_range(0, 799)), int'($urandom_range(0, 479))}};
            foreach (pts[i]) begin
                if ($urandom_range(0, 3) == 0) begin
                    rx = $urandom_range(1, 799);
                    ry = $urandom_range(0, 524);
                    drive(rx, ry, 0, 0);
                end
                drive(pts[i][0], pts[i][1], 1, $urandom_range(0, 9) == 0);
            end
        end

        drive(10, 10, 0, 0);
        drive(10, 10, 0, 0);
        check("queue_drained", q.size(), 0);
        check("miss_saturated", int'(bus.missCount), miss);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
